// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt dispatcher: controller state encoding
// and the default source count / index width.
package irq_pkg;

  localparam int N_SRC_DEF = 8;
  localparam int ID_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_arbiter.sv
// Rotating-start priority selector. The search begins at index 'start' and
// walks upward, wrapping from N_SRC-1 to 0; the first set request wins.
// With start tied to 0 this is plain lowest-index-first priority.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic [N_SRC-1:0] grant,
  output logic [ID_W-1:0]  index,
  output logic             valid
);

  // Scan all sources once from the start position and keep the first hit.
  always_comb begin
    int j;
    grant = '0;
    index = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N_SRC; k++) begin
      j = int'(start) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        index    = ID_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: edge-captures N_SRC level request lines into a
// pending register, filters them through a writable mask and presents one
// merged request to the CPU. The CPU acknowledges to learn the source index
// and signals end-of-interrupt to release the dispatcher.
//
// Handshake: cpu_irq is high exactly while the controller waits in REQ.
// A one-cycle cpu_ack pulse seen in REQ (with an enabled pending source)
// takes the interrupt: src_grant pulses one-hot for one cycle, irq_id is
// loaded and busy rises. A one-cycle cpu_eoi pulse in SERVICE ends it.
// cpu_ack outside REQ and cpu_eoi outside SERVICE have no effect; if both
// arrive together in REQ the ack is taken.
//
// Build option: define IRQ_DISPATCH_ROUND_ROBIN_EN to rotate priority,
// starting the search one above the last granted index. Without it the
// lowest enabled pending index always wins.
//
// fsm_state exposes the controller state for observation.
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             cpu_ack,
  input  logic             cpu_eoi,
  output logic             cpu_irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] src_grant,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  state_t           state;
  logic [N_SRC-1:0] src_sync;
  logic [N_SRC-1:0] src_prev;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] arb_grant;
  logic [ID_W-1:0]  arb_index;
  logic [ID_W-1:0]  arb_start;
  logic             arb_valid;
  logic             take;

  assign rise      = src_sync & ~src_prev;
  assign take      = (state == REQ) && arb_valid && cpu_ack;
  assign fsm_state = state;

  // Register the raw lines, then keep one older copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_sync <= '0;
      src_prev <= '0;
    end else begin
      src_sync <= src_irq;
      src_prev <= src_sync;
    end
  end

  // Mask register; writable in every state, all sources enabled after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask <= '1;
    else if (mask_we) mask <= mask_wdata;
  end

  // Pending bits: set by edges, cleared on grant; a fresh edge wins the tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else pending <= (pending & ~(take ? arb_grant : '0)) | rise;
  end

`ifdef IRQ_DISPATCH_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_ptr;

  // Remember the last granted index; reset value makes the first search start at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_ptr <= ID_W'(N_SRC - 1);
    else if (take) last_ptr <= arb_index;
  end

  assign arb_start = (last_ptr == ID_W'(N_SRC - 1)) ? '0 : last_ptr + ID_W'(1);
`else
  assign arb_start = '0;
`endif

  irq_arbiter #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_arbiter (
    .req   (pending & mask),
    .start (arb_start),
    .grant (arb_grant),
    .index (arb_index),
    .valid (arb_valid)
  );

  // Controller: request, acknowledge and service sequencing with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cpu_irq   <= 1'b0;
      busy      <= 1'b0;
      irq_id    <= '0;
      src_grant <= '0;
    end else begin
      src_grant <= '0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state   <= REQ;
            cpu_irq <= 1'b1;
          end
        end
        REQ: begin
          if (!arb_valid) begin
            // Mask change removed every candidate: withdraw the request.
            state   <= IDLE;
            cpu_irq <= 1'b0;
          end else if (cpu_ack) begin
            state     <= SERVICE;
            cpu_irq   <= 1'b0;
            busy      <= 1'b1;
            irq_id    <= arb_index;
            src_grant <= arb_grant;
          end
        end
        SERVICE: begin
          if (cpu_eoi) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cpu_irq <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/irq_dispatch.md
IRQ_DISPATCH -- requirements
Module: irq_dispatch

Interface
REQ-001 Parameter N_SRC, default 8, number of interrupt sources (2..32).
REQ-002 Parameter ID_W, default 3, width of source index; SHALL equal clog2(N_SRC).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 src_irq  input  N_SRC  level request lines from sources.
REQ-006 mask_we  input  1  write strobe for mask register.
REQ-007 mask_wdata  input  N_SRC  new mask value (1 = source enabled).
REQ-008 cpu_ack  input  1  CPU acknowledge pulse, one cycle.
REQ-009 cpu_eoi  input  1  CPU end-of-interrupt pulse, one cycle.
REQ-010 cpu_irq  output  1  merged interrupt request to CPU.
REQ-011 irq_id  output  ID_W  index of granted source.
REQ-012 src_grant  output  N_SRC  one-hot acknowledge back to the granted source.
REQ-013 busy  output  1  high while an interrupt is in service.

Function
REQ-014 The block SHALL capture each 0->1 edge of src_irq[i] into pending[i]; src_irq sampled through one register stage.
REQ-015 pending[i] SHALL stay set until granted; a new edge on the same cycle as its clear SHALL leave pending[i] set.
REQ-016 FSM states IDLE, REQ, SERVICE; reset state IDLE.
REQ-017 IDLE -> REQ when (pending & mask) != 0; cpu_irq SHALL be 1 exactly in REQ, registered.
REQ-018 Latency: source edge to cpu_irq = 3 cycles (sync, pending, state).
REQ-019 In REQ, cpu_ack SHALL select one source per REQ-027, drive src_grant one-hot for exactly one cycle, load irq_id, clear that pending bit, go to SERVICE.
REQ-020 If mask change in REQ leaves (pending & mask) == 0, FSM SHALL return to IDLE next cycle; cpu_ack in that cycle ignored.
REQ-021 In SERVICE, busy = 1, irq_id held; cpu_eoi SHALL return to IDLE; cpu_ack in SERVICE ignored.
REQ-022 cpu_eoi outside SERVICE SHALL be ignored; cpu_ack and cpu_eoi together in REQ: ack wins.
REQ-023 mask_we SHALL update mask next edge in any state; masked sources still accumulate pending.

Reset
REQ-024 On reset assertion, immediately: state IDLE, pending 0, mask all ones, irq_id 0, src_grant 0, cpu_irq 0, busy 0.
REQ-025 Reset mid-SERVICE SHALL discard the in-service interrupt; no grant or pending bit is restored.
REQ-026 Edges present during reset SHALL NOT be captured; sync register resets to 0, so a line high at release registers one edge.

Configuration
REQ-027 Macro IRQ_DISPATCH_ROUND_ROBIN_EN: defined -> round-robin, search starts one above last granted index, wrapping N_SRC-1 -> 0; undefined -> fixed priority, lowest index wins.
REQ-028 Round-robin pointer SHALL reset to N_SRC-1, so the first grant after reset equals fixed priority.

Structure
REQ-029 Shared package irq_pkg SHALL hold the state enum (IDLE, REQ, SERVICE) and default N_SRC/ID_W constants.
REQ-030 Selection logic SHALL be sub-module irq_arbiter (inputs request vector, start pointer; outputs one-hot grant, index, valid).

Verification
REQ-031 src_irq[5] rises at cycle 0 -> cpu_irq=1 at cycle 3; cpu_ack -> src_grant=8'h20 for one cycle, irq_id=5, busy=1.
REQ-032 src_irq[2] and src_irq[6] rise together, fixed priority -> first ack irq_id=2; after eoi second ack irq_id=6.
REQ-033 ROUND_ROBIN_EN, last grant 6, pending {1,7} -> next irq_id=7, then 1 (wrap).
REQ-034 mask=8'h00, src_irq[3] rises -> cpu_irq stays 0; write mask=8'h08 -> cpu_irq=1 two cycles later, ack gives irq_id=3.
REQ-035 Reset during SERVICE with src_irq[4] pending -> all outputs 0 immediately, pending cleared, cpu_irq 0 after release until a new edge.
REQ-036 src_irq[1] re-edges on the same cycle as its grant -> pending[1] remains 1, cpu_irq reasserts after eoi.
